// File: rtl/rv_pkg.sv
// Shared RV32I decode types, opcode encodings and the instruction-field decoder.
// Build option: define RV_M_EXT_EN to add the M-extension ALU operations.
package rv_pkg;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC
  } op_class_e;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU,
    ALU_B, ALU_H, ALU_W, ALU_BU, ALU_HU
`ifdef RV_M_EXT_EN
    , ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
`endif
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    alu_op_e    alu_op;
    op_class_e  cls;
    logic       rd_we;
    logic       illegal;
  } dec_t;

  localparam dec_t DEC_RESET = '{rd: 5'd0, rs1: 5'd0, rs2: 5'd0, alu_op: ALU_ADD,
                                 cls: CLS_ALU_I, rd_we: 1'b0, illegal: 1'b0};

  function automatic dec_t rv_decode(input logic [31:0] instr, output imm_fmt_e fmt);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       writes;
    f3        = instr[14:12];
    f7        = instr[31:25];
    d.rd      = instr[11:7];
    d.rs1     = instr[19:15];
    d.rs2     = instr[24:20];
    d.alu_op  = ALU_ADD;
    d.cls     = CLS_ALU_I;
    d.illegal = 1'b0;
    fmt       = IMM_I;
    writes    = 1'b1;
    case (instr[6:0])
      OPCODE_LUI:   begin d.cls = CLS_LUI;   fmt = IMM_U; end
      OPCODE_AUIPC: begin d.cls = CLS_AUIPC; fmt = IMM_U; end
      OPCODE_JAL:   begin d.cls = CLS_JAL;   fmt = IMM_J; end
      OPCODE_JALR:  begin d.cls = CLS_JALR;  d.illegal = (f3 != 3'b000); end
      OPCODE_BRANCH: begin
        d.cls = CLS_BRANCH; fmt = IMM_B; writes = 1'b0;
        case (f3)
          3'b000:  d.alu_op = ALU_EQ;
          3'b001:  d.alu_op = ALU_NE;
          3'b100:  d.alu_op = ALU_LT;
          3'b101:  d.alu_op = ALU_GE;
          3'b110:  d.alu_op = ALU_LTU;
          3'b111:  d.alu_op = ALU_GEU;
          default: d.illegal = 1'b1;
        endcase
      end
      OPCODE_LOAD: begin
        d.cls = CLS_LOAD;
        case (f3)
          3'b000:  d.alu_op = ALU_B;
          3'b001:  d.alu_op = ALU_H;
          3'b010:  d.alu_op = ALU_W;
          3'b100:  d.alu_op = ALU_BU;
          3'b101:  d.alu_op = ALU_HU;
          default: d.illegal = 1'b1;
        endcase
      end
      OPCODE_STORE: begin
        d.cls = CLS_STORE; fmt = IMM_S; writes = 1'b0;
        case (f3)
          3'b000:  d.alu_op = ALU_B;
          3'b001:  d.alu_op = ALU_H;
          3'b010:  d.alu_op = ALU_W;
          default: d.illegal = 1'b1;
        endcase
      end
      OPCODE_OP_IMM: begin
        case (f3)
          3'b000: d.alu_op = ALU_ADD;
          3'b010: d.alu_op = ALU_SLT;
          3'b011: d.alu_op = ALU_SLTU;
          3'b100: d.alu_op = ALU_XOR;
          3'b110: d.alu_op = ALU_OR;
          3'b111: d.alu_op = ALU_AND;
          3'b001: begin d.alu_op = ALU_SLL; fmt = IMM_SHAMT; d.illegal = (f7 != 7'b0000000); end
          default: begin
            d.alu_op  = instr[30] ? ALU_SRA : ALU_SRL;
            fmt       = IMM_SHAMT;
            d.illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          end
        endcase
      end
      OPCODE_OP: begin
        d.cls = CLS_ALU_R; fmt = IMM_NONE;
        if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
          case (f3)
            3'b000: d.alu_op = instr[30] ? ALU_SUB : ALU_ADD;
            3'b001: d.alu_op = ALU_SLL;
            3'b010: d.alu_op = ALU_SLT;
            3'b011: d.alu_op = ALU_SLTU;
            3'b100: d.alu_op = ALU_XOR;
            3'b101: d.alu_op = instr[30] ? ALU_SRA : ALU_SRL;
            3'b110: d.alu_op = ALU_OR;
            3'b111: d.alu_op = ALU_AND;
          endcase
          // only ADD and SRL have a funct7 = 0100000 variant
          d.illegal = instr[30] && (f3 != 3'b000) && (f3 != 3'b101);
        end
`ifdef RV_M_EXT_EN
        else if (f7 == 7'b0000001) begin
          case (f3)
            3'b000: d.alu_op = ALU_MUL;
            3'b001: d.alu_op = ALU_MULH;
            3'b010: d.alu_op = ALU_MULHSU;
            3'b011: d.alu_op = ALU_MULHU;
            3'b100: d.alu_op = ALU_DIV;
            3'b101: d.alu_op = ALU_DIVU;
            3'b110: d.alu_op = ALU_REM;
            3'b111: d.alu_op = ALU_REMU;
          endcase
        end
`endif
        else begin
          d.illegal = 1'b1;
        end
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d.cls    = CLS_ALU_I;
      d.alu_op = ALU_ADD;
      fmt      = IMM_NONE;
    end
    d.rd_we = writes && !d.illegal && (d.rd != 5'd0);
    return d;
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate extraction for the RV32I formats, sign-extended to XLEN.
module rv_imm_gen import rv_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);
  logic [31:0] raw;

  always_comb begin
    raw = '0;
    case (fmt_i)
      IMM_I:     raw = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:     raw = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:     raw = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      IMM_U:     raw = {instr_i[31:12], 12'b0};
      IMM_J:     raw = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      IMM_SHAMT: raw = {27'b0, instr_i[24:20]};
      default:   raw = '0;
    endcase
    // raw is already correct as a signed 32-bit value; widen for XLEN = 64
    imm_o = XLEN'($signed(raw));
  end
endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage: valid/ready on both sides, optional skid slot, flush.
// Build option: define RV_M_EXT_EN to decode the M extension.
module rv_decode_stage import rv_pkg::*; #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned SKID  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output alu_op_e          out_alu_op,
  output op_class_e        out_class,
  output logic             out_rd_we,
  output logic             out_illegal
);
  localparam bit HAS_SKID = (SKID != 0);

  dec_t             in_dec;
  imm_fmt_e         in_fmt;
  logic [XLEN-1:0]  in_imm;

  logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  dec_t             m_dec_q, s_dec_q;
  logic [XLEN-1:0]  m_pc_q, s_pc_q, m_imm_q, s_imm_q;
  logic [TAG_W-1:0] m_tag_q, s_tag_q;
  logic             m_free, accept, load_m_in, load_m_s, load_s;

  always_comb in_dec = rv_decode(in_instr, in_fmt);

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (in_instr),
    .fmt_i   (in_fmt),
    .imm_o   (in_imm)
  );

  assign in_ready = HAS_SKID ? !s_valid_q : (!m_valid_q || out_ready);
  assign m_free   = !m_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // S is only ever occupied while M is held, so it refills M before any new input
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (m_free) begin
      if (s_valid_q) begin
        load_m_s  = 1'b1;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else begin
        load_m_in = accept;
        m_valid_d = accept;
      end
    end else if (accept) begin
      load_s    = 1'b1;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_dec_q   <= DEC_RESET;
      s_dec_q   <= DEC_RESET;
      m_pc_q    <= '0;
      s_pc_q    <= '0;
      m_imm_q   <= '0;
      s_imm_q   <= '0;
      m_tag_q   <= '0;
      s_tag_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      if (load_m_in) begin
        m_dec_q <= in_dec;
        m_pc_q  <= in_pc;
        m_imm_q <= in_imm;
        m_tag_q <= in_tag;
      end else if (load_m_s) begin
        m_dec_q <= s_dec_q;
        m_pc_q  <= s_pc_q;
        m_imm_q <= s_imm_q;
        m_tag_q <= s_tag_q;
      end
      if (load_s) begin
        s_dec_q <= in_dec;
        s_pc_q  <= in_pc;
        s_imm_q <= in_imm;
        s_tag_q <= in_tag;
      end
    end
  end

  assign out_valid   = m_valid_q;
  assign out_pc      = m_pc_q;
  assign out_tag     = m_tag_q;
  assign out_imm     = m_imm_q;
  assign out_rd      = m_dec_q.rd;
  assign out_rs1     = m_dec_q.rs1;
  assign out_rs2     = m_dec_q.rs2;
  assign out_alu_op  = m_dec_q.alu_op;
  assign out_class   = m_dec_q.cls;
  assign out_rd_we   = m_dec_q.rd_we;
  assign out_illegal = m_dec_q.illegal;
endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage: directed scenarios plus a randomized scoreboard run.
module tb_rv_decode_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [3:0]  in_tag = '0;
  logic        in_ready, out_valid, out_rd_we, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [3:0]  out_tag;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  alu_op_e     out_alu_op;
  op_class_e   out_class;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  tag;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    alu_op_e     alu;
    op_class_e   cls;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(32), .TAG_W(4), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_tag(out_tag),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_class(out_class), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  // Reference decode from ISA tables and arithmetic on the instruction fields.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc, input logic [3:0] tag);
    exp_t e;
    int f3, si;
    logic [6:0] f7;
    logic wr;
    alu_op_e base [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    alu_op_e br   [8] = '{ALU_EQ, ALU_NE, ALU_ADD, ALU_ADD, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU};
    alu_op_e mem  [8] = '{ALU_B, ALU_H, ALU_W, ALU_ADD, ALU_BU, ALU_HU, ALU_ADD, ALU_ADD};
`ifdef RV_M_EXT_EN
    alu_op_e mext [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
`endif
    logic [7:0] br_ok = 8'b1111_0011;
    logic [7:0] ld_ok = 8'b0011_0111;
    logic [7:0] st_ok = 8'b0000_0111;
    e.pc = pc; e.tag = tag;
    e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
    e.imm = '0; e.alu = ALU_ADD; e.cls = CLS_ALU_I; e.ill = 1'b0; wr = 1'b1;
    f3 = int'(i[14:12]);
    f7 = i[31:25];
    si = int'($signed(i));
    case (i[6:0])
      7'h37: begin e.cls = CLS_LUI;   e.imm = i & 32'hFFFF_F000; end
      7'h17: begin e.cls = CLS_AUIPC; e.imm = i & 32'hFFFF_F000; end
      7'h6F: begin
        e.cls = CLS_JAL;
        e.imm = (si >>> 31) * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      end
      7'h67: begin e.cls = CLS_JALR; e.ill = (f3 != 0); e.imm = si >>> 20; end
      7'h63: begin
        e.cls = CLS_BRANCH; wr = 1'b0; e.alu = br[f3]; e.ill = !br_ok[f3];
        e.imm = (si >>> 31) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      end
      7'h03: begin e.cls = CLS_LOAD; e.alu = mem[f3]; e.ill = !ld_ok[f3]; e.imm = si >>> 20; end
      7'h23: begin
        e.cls = CLS_STORE; wr = 1'b0; e.alu = mem[f3]; e.ill = !st_ok[f3];
        e.imm = (si >>> 25) * 32 + int'(i[11:7]);
      end
      7'h13: begin
        if (f3 == 1 || f3 == 5) begin
          e.imm = int'(i[24:20]);
          e.alu = (f3 == 1) ? ALU_SLL : ((f7 == 7'h20) ? ALU_SRA : ALU_SRL);
          e.ill = !(f7 == 7'h00 || (f3 == 5 && f7 == 7'h20));
        end else begin
          e.alu = base[f3];
          e.imm = si >>> 20;
        end
      end
      7'h33: begin
        e.cls = CLS_ALU_R;
        if (f7 == 7'h00) e.alu = base[f3];
        else if (f7 == 7'h20 && f3 == 0) e.alu = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 5) e.alu = ALU_SRA;
`ifdef RV_M_EXT_EN
        else if (f7 == 7'h01) e.alu = mext[f3];
`endif
        else e.ill = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.cls = CLS_ALU_I;
      e.alu = ALU_ADD;
    end
    e.we = wr && !e.ill && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic [31:0] w;
    int k;
    w = $urandom();
    k = int'($urandom_range(0, 11));
    if (k <= 8) w[6:0] = opcs[k];
    else if (k == 9) w[6:0] = 7'h33;
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    n_cmp++;
    if (out_pc !== 0 || out_tag !== 0 || out_rd !== 0 || out_rs1 !== 0 || out_rs2 !== 0 || out_imm !== 0 ||
        out_alu_op !== ALU_ADD || out_class !== CLS_ALU_I || out_rd_we !== 0 || out_illegal !== 0) begin
      n_bad++;
      $display("FAIL reset_data: pc=%h imm=%h rd=%0d alu=%s cls=%s we=%b ill=%b, required zeros/ADD/ALU_I",
               out_pc, out_imm, out_rd, out_alu_op.name(), out_class.name(), out_rd_we, out_illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h100; in_tag = 4'h3; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1 || out_rd !== 1 || out_rs1 !== 2 || out_imm !== 32'hFFFF_FFFF || out_alu_op !== ALU_ADD ||
        out_class !== CLS_ALU_I || out_rd_we !== 1 || out_illegal !== 0 || out_pc !== 32'h100 || out_tag !== 3) begin
      n_bad++;
      $display("FAIL addi: v=%b rd=%0d rs1=%0d imm=%h alu=%s we=%b pc=%h tag=%0d, required 1 1 2 ffffffff ADD 1 100 3",
               out_valid, out_rd, out_rs1, out_imm, out_alu_op.name(), out_rd_we, out_pc, out_tag);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL addi_drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_sub_illegal();
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h402081B3; in_tag = 4'h1; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1 || out_alu_op !== ALU_SUB || out_class !== CLS_ALU_R || out_rd !== 3 || out_rs1 !== 1 ||
        out_rs2 !== 2 || out_rd_we !== 1 || out_illegal !== 0 || out_imm !== 0 || out_tag !== 1) begin
      n_bad++;
      $display("FAIL sub: v=%b alu=%s cls=%s rd=%0d rs1=%0d rs2=%0d we=%b ill=%b imm=%h tag=%0d, required SUB ALU_R 3 1 2 1 0 0 1",
               out_valid, out_alu_op.name(), out_class.name(), out_rd, out_rs1, out_rs2, out_rd_we, out_illegal, out_imm, out_tag);
    end
    in_instr = 32'h40109093; in_tag = 4'h2;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1 || out_illegal !== 1 || out_rd_we !== 0 || out_class !== CLS_ALU_I ||
        out_alu_op !== ALU_ADD || out_tag !== 2) begin
      n_bad++;
      $display("FAIL slli_bad_f7: v=%b ill=%b we=%b cls=%s alu=%s tag=%0d, required 1 1 0 ALU_I ADD 2",
               out_valid, out_illegal, out_rd_we, out_class.name(), out_alu_op.name(), out_tag);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL sub_drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    logic [3:0] tags[$];
    logic [4:0] rds[$];
    logic ok;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      out_ready = !(c >= 1 && c <= 3);
      in_valid  = (sent < 4);
      in_instr  = {12'd7, 5'd0, 3'b000, 5'(sent + 1), 7'h13};
      in_tag    = 4'(sent);
      if (c == 2) begin
        n_cmp++;
        if (in_ready !== 1'b0 || sent != 2) begin
          n_bad++;
          $display("FAIL bp_in_ready: in_ready=%b accepted=%0d, required 0 after 2", in_ready, sent);
        end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        tags.push_back(out_tag);
        rds.push_back(out_rd);
      end
    end
    in_valid = 1'b0;
    ok = (tags.size() == 4);
    for (int k = 0; k < tags.size(); k++)
      if (tags[k] != 4'(k) || rds[k] != 5'(k + 1)) ok = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL bp_order: got %0d entries tags=%p, required 4 entries tags 0,1,2,3", tags.size(), tags);
    end
  endtask

  task automatic test_mul();
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h027302B3; in_tag = 4'h5; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
`ifdef RV_M_EXT_EN
    if (out_valid !== 1 || out_alu_op !== ALU_MUL || out_class !== CLS_ALU_R || out_illegal !== 0 ||
        out_rd_we !== 1 || out_rd !== 5 || out_rs1 !== 6 || out_rs2 !== 7) begin
      n_bad++;
      $display("FAIL mul: v=%b alu=%s cls=%s ill=%b we=%b, required 1 MUL ALU_R 0 1",
               out_valid, out_alu_op.name(), out_class.name(), out_illegal, out_rd_we);
    end
`else
    if (out_valid !== 1 || out_illegal !== 1 || out_rd_we !== 0 || out_class !== CLS_ALU_I || out_alu_op !== ALU_ADD) begin
      n_bad++;
      $display("FAIL mul_illegal: v=%b ill=%b we=%b cls=%s alu=%s, required 1 1 0 ALU_I ADD",
               out_valid, out_illegal, out_rd_we, out_class.name(), out_alu_op.name());
    end
`endif
  endtask

  task automatic test_flush();
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 4'h1; out_ready = 1'b0;
    @(negedge clk);
    in_tag = 4'h2;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1 || in_ready !== 0 || out_tag !== 1) begin
      n_bad++;
      $display("FAIL flush_prefill: v=%b in_ready=%b tag=%0d, required 1 0 1", out_valid, in_ready, out_tag);
    end
    flush = 1'b1; in_tag = 4'h3;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (out_valid !== 0 || in_ready !== 1) begin
      n_bad++;
      $display("FAIL flush_two: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b1; in_tag = 4'h4; out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1 || out_tag !== 4 || in_ready !== 1) begin
      n_bad++;
      $display("FAIL flush_one_prefill: v=%b tag=%0d in_ready=%b, required 1 4 1", out_valid, out_tag, in_ready);
    end
    flush = 1'b1; in_tag = 4'h5;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (out_valid !== 0 || in_ready !== 1) begin
        n_bad++;
        $display("FAIL flush_drop_input cycle %0d: out_valid=%b in_ready=%b tag=%0d, required 0 1",
                 c, out_valid, in_ready, out_tag);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_x0_reset();
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00500013; in_tag = 4'h6; out_ready = 1'b0;
    @(negedge clk);
    in_instr = 32'hFFF10093; in_tag = 4'h7;
    n_cmp++;
    if (out_valid !== 1 || out_rd_we !== 0 || out_rd !== 0 || out_imm !== 5 || out_illegal !== 0 || out_tag !== 6) begin
      n_bad++;
      $display("FAIL addi_x0: v=%b we=%b rd=%0d imm=%h ill=%b tag=%0d, required 1 0 0 5 0 6",
               out_valid, out_rd_we, out_rd, out_imm, out_illegal, out_tag);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 0 || in_ready !== 1 || out_tag !== 0 || out_imm !== 0 || out_alu_op !== ALU_ADD ||
        out_class !== CLS_ALU_I || out_rd_we !== 0) begin
      n_bad++;
      $display("FAIL async_reset: v=%b in_ready=%b tag=%0d imm=%h alu=%s cls=%s we=%b, required 0 1 0 0 ADD ALU_I 0",
               out_valid, in_ready, out_tag, out_imm, out_alu_op.name(), out_class.name(), out_rd_we);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 0) begin
      n_bad++;
      $display("FAIL reset_lost: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_random();
    exp_t h;
    logic acc;
    q.delete();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
        n_bad++;
        $display("FAIL rand_hs cycle %0d: out_valid=%b in_ready=%b, required %b %b",
                 c, out_valid, in_ready, q.size() != 0, q.size() < 2);
      end
      if (q.size() != 0) begin
        h = q[0];
        n_cmp++;
        if (out_pc !== h.pc || out_tag !== h.tag || out_alu_op !== h.alu || out_class !== h.cls ||
            out_rd_we !== h.we || out_illegal !== h.ill ||
            (!h.ill && (out_rd !== h.rd || out_rs1 !== h.rs1 || out_rs2 !== h.rs2 || out_imm !== h.imm))) begin
          n_bad++;
          $display("FAIL rand_entry cycle %0d: got pc=%h tag=%0d rd=%0d rs1=%0d rs2=%0d imm=%h alu=%s cls=%s we=%b ill=%b; required pc=%h tag=%0d rd=%0d rs1=%0d rs2=%0d imm=%h alu=%s cls=%s we=%b ill=%b",
                   c, out_pc, out_tag, out_rd, out_rs1, out_rs2, out_imm, out_alu_op.name(), out_class.name(), out_rd_we, out_illegal,
                   h.pc, h.tag, h.rd, h.rs1, h.rs2, h.imm, h.alu.name(), h.cls.name(), h.we, h.ill);
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom();
      in_tag    = 4'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      acc = in_valid && (q.size() < 2);
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (acc) q.push_back(model(in_instr, in_pc, in_tag));
      end
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_addi();
    test_sub_illegal();
    test_backpressure();
    test_mul();
    test_flush();
    test_x0_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

Registered, parametrised RV32I instruction decode stage with a valid/ready handshake on both sides. It accepts an instruction word, PC and sideband tag from fetch. It emits register indices, a sign-extended immediate, an ALU operation, an instruction class and an illegal-instruction flag to execute. A two-entry skid buffer sustains one instruction per cycle under back-pressure. A synchronous flush discards in-flight entries on redirect.

## Interface
- XLEN, 32: width of PC and immediate; 32 or 64, immediates sign-extended to XLEN.
- TAG_W, 4: width of opaque sideband tag carried with each instruction.
- SKID, 1: 1 = two-entry skid buffer (full throughput); 0 = single register (in_ready = !out_valid || out_ready).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all held entries.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  execute accepts.
- out_pc  out  XLEN, out_tag  out  TAG_W  passed through.
- out_rd, out_rs1, out_rs2  out  5  register indices.
- out_imm  out  XLEN  sign-extended immediate (0 for R-type).
- out_alu_op  out  alu_op_e  ALU operation.
- out_class  out  op_class_e  ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
- out_rd_we  out  1  writes rd (forced 0 when rd = x0 or illegal).
- out_illegal  out  1  unrecognised encoding.

## Operation
- Transfer occurs when valid && ready on the respective side, sampled on the rising clk edge.
- Decode uses opcode[6:0], funct3[14:12] and funct7[31:25]. The OP opcode is 7'b0110011 and the OP-IMM opcode is 7'b0010011.
- SLLI/SRLI require funct7 = 0. SRAI requires funct7 = 7'b0100000. ADD/SUB and SRL/SRA are selected by instr[30]. Any other funct7 on OP or OP-IMM is illegal.
- Immediate formats I/S/B/U/J follow the ISA. For shift immediates, out_imm = zero-extended shamt[4:0].
- Branch alu_op encodes the comparison: EQ, NE, LT, GE, LTU, GEU. Loads and stores carry width/sign in alu_op: B, H, W, BU, HU.
- Illegal entries: out_illegal = 1, out_rd_we = 0, out_class = ALU_I, out_alu_op = ADD, and the entry is still delivered in order.
- Skid (SKID = 1):
  - Main register M and skid register S.
  - in_ready = !S.valid.
  - Input is accepted into M when M is empty or being drained; otherwise it goes into S.
  - When M drains, S moves to M.
- flush: M.valid and S.valid are cleared at the next edge. An input handshaking in the same cycle is dropped. Flush has priority over every other event.

## Timing
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 per cycle while out_ready = 1.
- Reset values:
  - out_valid = 0, in_ready = 1.
  - All data outputs = 0, out_alu_op = ADD, out_class = ALU_I.
- Under reset assertion mid-stream, all held entries are lost immediately (asynchronous).
- in_ready depends only on registered state; no combinational in→out ready path.
- Output data is stable while out_valid && !out_ready.
- The cycle after flush: out_valid = 0, in_ready = 1.

## Configuration
- RV_M_EXT_EN defined: OP with funct7 = 7'b0000001 decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU as class ALU_R with the matching alu_op.
- RV_M_EXT_EN undefined: those encodings are illegal, and the M alu_op values are absent from the enum.

## Structure
- Package rv holds:
  - op_class_e and alu_op_e (M values under RV_M_EXT_EN).
  - imm_fmt_e (I, S, B, U, J, SHAMT, NONE).
  - OPCODE_* localparams for all nine base opcodes, with the correct encodings.
- Sub-module rv_imm_gen: combinational; takes instr and imm_fmt_e, produces the XLEN-wide immediate.

## Test plan
- ADDI x1,x2,-1 (0xFFF10093), out_ready = 1 → one cycle later: rd = 1, rs1 = 2, imm = all ones, alu ADD, rd_we = 1.
- SUB x3,x1,x2 (0x402081B3) then SLLI with funct7 = 0100000 (0x40109093) → SUB decoded; second entry illegal = 1, rd_we = 0, order preserved.
- Stream of 4 instructions with out_ready held low from cycle 1 for 3 cycles:
  - in_ready = 0 after 2 accepted.
  - All 4 emerge in order, no loss or duplicate.
- MUL x5,x6,x7 (0x027302B3) → alu MUL, class ALU_R with RV_M_EXT_EN; illegal = 1 without it.
- Two entries held, flush = 1 with in_valid = 1 → next cycle out_valid = 0, in_ready = 1, flushed-cycle input never appears.
- ADDI x0,x0,5 (0x00500013) → rd_we = 0. rst_n pulsed low mid-stream → out_valid drops asynchronously, outputs return to reset values.
